// File: rtl/easyaxi_rd_arb_if.sv
// EasyAXI read-channel bundle: N lanes of AR/R valid-ready with one shared R payload.
// AXI width macros fall back to defaults when the build does not set them.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

interface easyaxi_rd_arb_if #(
  parameter int N    = 1,
  parameter int ID_W = `AXI_ID_W
);
  logic [N-1:0]                arvalid;
  logic [N-1:0]                arready;
  logic [N*ID_W-1:0]           arid;
  logic [N*`AXI_ADDR_W-1:0]    araddr;
  logic [N*`AXI_LEN_W-1:0]     arlen;
  logic [N*`AXI_SIZE_W-1:0]    arsize;
  logic [N*`AXI_BURST_W-1:0]   arburst;
  logic [N-1:0]                rvalid;
  logic [N-1:0]                rready;
  logic [ID_W-1:0]             rid;
  logic [`AXI_DATA_W-1:0]      rdata;
  logic [`AXI_RESP_W-1:0]      rresp;
  logic                        rlast;

  modport master (
    output arvalid, arid, araddr, arlen,
    output arsize, arburst, rready,
    input  arready, rvalid, rid, rdata,
    input  rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen,
    input  arsize, arburst, rready,
    output arready, rvalid, rid, rdata,
    output rresp, rlast
  );
endinterface

// File: rtl/easyaxi_rd_arb.sv
// Read arbiter: MST_NUM EasyAXI masters share one slave AR/R port, RID-routed.
// EASYAXI_RD_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif

module easyaxi_rd_arb #(
  parameter int MST_NUM = 2,
  parameter int OST_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  easyaxi_rd_arb_if.slave  mst,
  easyaxi_rd_arb_if.master slv,
  output logic             idle
);
  localparam int IDX_W = $clog2(MST_NUM);
  localparam int CNT_W = $clog2(OST_MAX) + 1;
  localparam int IW    = `AXI_ID_W;
  localparam int AW    = `AXI_ADDR_W;
  localparam int LW    = `AXI_LEN_W;
  localparam int SW    = `AXI_SIZE_W;
  localparam int BW    = `AXI_BURST_W;

  typedef enum logic {ARB, LOCK} state_t;

  state_t             state_r, state_nxt;
  logic [CNT_W-1:0]   ost_cnt [MST_NUM];
  logic [MST_NUM-1:0] elig, inc, dec;
  logic [IDX_W-1:0]   grant_r, arb_idx, gnt;
  logic               arb_vld, gnt_vld, ar_hs;
  logic [IDX_W-1:0]   ridx;

  always_comb begin
    elig = '0;
    for (int k = 0; k < MST_NUM; k++)
      elig[k] = mst.arvalid[k] &&
                (ost_cnt[k] != CNT_W'(OST_MAX));
  end

`ifdef EASYAXI_RD_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int k = MST_NUM - 1; k >= 0; k--)
      if (elig[k]) begin
        arb_vld = 1'b1;
        arb_idx = IDX_W'(k);
      end
  end
`else
  logic [IDX_W-1:0]   last_grant_r;
  logic [MST_NUM-1:0] rot;

  // rot[i] is the requester i+1 slots after the last winner
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    rot = MST_NUM'({elig, elig} >> (int'(last_grant_r) + 1));
    for (int i = MST_NUM - 1; i >= 0; i--)
      if (rot[i]) begin
        arb_vld = 1'b1;
        arb_idx = IDX_W'((int'(last_grant_r) + 1 + i) % MST_NUM);
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant_r <= IDX_W'(MST_NUM - 1);
    else if (ar_hs) last_grant_r <= gnt;
  end
`endif

  always_comb begin
    state_nxt = state_r;
    gnt       = arb_idx;
    gnt_vld   = arb_vld;
    unique case (state_r)
      ARB:
        if (arb_vld && !slv.arready) state_nxt = LOCK;
      LOCK: begin
        gnt     = grant_r;
        gnt_vld = 1'b1;
        if (slv.arready) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      grant_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (gnt_vld) grant_r <= gnt;
    end
  end

  assign ar_hs = gnt_vld && slv.arready;

  always_comb begin
    slv.arvalid = gnt_vld;
    slv.arid    = '0;
    slv.araddr  = '0;
    slv.arlen   = '0;
    slv.arsize  = '0;
    slv.arburst = '0;
    mst.arready = '0;
    inc         = '0;
    for (int k = 0; k < MST_NUM; k++)
      if (gnt == IDX_W'(k)) begin
        slv.arid    = {gnt, mst.arid[k*IW +: IW]};
        slv.araddr  = mst.araddr[k*AW +: AW];
        slv.arlen   = mst.arlen[k*LW +: LW];
        slv.arsize  = mst.arsize[k*SW +: SW];
        slv.arburst = mst.arburst[k*BW +: BW];
        mst.arready[k] = ar_hs;
        inc[k]         = ar_hs;
      end
  end

  // Beats tagged with an index beyond MST_NUM fall through: accepted, dropped
  assign ridx = slv.rid[IW +: IDX_W];

  always_comb begin
    mst.rvalid = '0;
    slv.rready = 1'b1;
    dec        = '0;
    for (int k = 0; k < MST_NUM; k++)
      if (ridx == IDX_W'(k)) begin
        mst.rvalid[k] = slv.rvalid;
        slv.rready    = mst.rready[k];
        dec[k] = slv.rvalid && mst.rready[k] && slv.rlast;
      end
  end

  assign mst.rid   = slv.rid[IW-1:0];
  assign mst.rdata = slv.rdata;
  assign mst.rresp = slv.rresp;
  assign mst.rlast = slv.rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MST_NUM; k++) ost_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < MST_NUM; k++)
        if (inc[k] && !dec[k])
          ost_cnt[k] <= ost_cnt[k] + 1'b1;
        else if (dec[k] && !inc[k])
          ost_cnt[k] <= ost_cnt[k] - 1'b1;
    end
  end

  always_comb begin
    idle = !gnt_vld;
    for (int k = 0; k < MST_NUM; k++)
      if (ost_cnt[k] != '0) idle = 1'b0;
  end
endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Randomized scoreboard bench for easyaxi_rd_arb, two masters, OST_MAX=2.
// Driver predicts from a transaction-level model; a negedge monitor checks.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_arb;
  localparam int N     = 2;
  localparam int OST   = 2;
  localparam int IDX_W = $clog2(N);
  localparam int IW    = `AXI_ID_W;
  localparam int AW    = `AXI_ADDR_W;
  localparam int LW    = `AXI_LEN_W;
  localparam int SW    = `AXI_SIZE_W;
  localparam int BW    = `AXI_BURST_W;
  localparam int DW    = `AXI_DATA_W;
  localparam int RW    = `AXI_RESP_W;

  typedef struct {
    int cyc; int m; logic [IW-1:0] id;
    logic [AW-1:0] addr; logic [LW-1:0] len;
    logic [SW-1:0] size; logic [BW-1:0] burst;
    logic [N-1:0] ardy;
  } ar_exp_t;
  typedef struct {
    int cyc; int m; logic [IW-1:0] id;
    logic [DW-1:0] data; logic [RW-1:0] resp;
    logic last; logic rrdy;
  } r_exp_t;
  typedef struct { int cyc; logic arv; logic idl; } st_exp_t;
  typedef struct { int m; logic [IW-1:0] id; int len; } burst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle;
  always #5 clk = ~clk;

  easyaxi_rd_arb_if #(.N(N), .ID_W(IW))         mst ();
  easyaxi_rd_arb_if #(.N(1), .ID_W(IW + IDX_W)) slv ();

  easyaxi_rd_arb #(.MST_NUM(N), .OST_MAX(OST)) dut (
    .clk(clk), .rst_n(rst_n),
    .mst(mst), .slv(slv), .idle(idle)
  );

  int n_pass = 0;
  int n_chk  = 0;

  ar_exp_t aq[$];
  r_exp_t  rq[$];
  st_exp_t sq[$];
  burst_t  bq[$];

  // stimulus state: pending AR per master, slave R beat in flight
  bit            pv [N];
  logic [IW-1:0] pid [N];
  logic [AW-1:0] paddr [N];
  logic [LW-1:0] plen [N];
  logic [SW-1:0] psize [N];
  logic [BW-1:0] pburst [N];
  bit            r_on;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp;
  int            beat;
  int p_req, p_ardy, p_rv, p_rrdy;
  int cur_cyc = 0;
  bit mon_en = 1'b0;

  // reference model: outstanding bursts, last winner, held grant
  int cnt [N];
  int last;
  bit lck;
  int lck_m;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic miss(input string nm);
    n_chk++;
    $display("FAIL %s: cycle %0d got none expected one", nm, cur_cyc);
  endtask

  function automatic int pick(logic [N-1:0] el);
    int best;
`ifndef EASYAXI_RD_ARB_FIXED_PRIO_EN
    int bd;
    int d;
`endif
    best = -1;
`ifdef EASYAXI_RD_ARB_FIXED_PRIO_EN
    for (int m = N - 1; m >= 0; m--) if (el[m]) best = m;
`else
    bd = N;
    for (int m = 0; m < N; m++) begin
      d = (m - last - 1 + N) % N;
      if (el[m] && d < bd) begin bd = d; best = m; end
    end
`endif
    return best;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < N; m++) begin cnt[m] = 0; pv[m] = 0; end
    last = N - 1; lck = 0; lck_m = 0;
    r_on = 0; beat = 0; bq.delete();
  endtask

  task automatic drive_zero();
    mst.arvalid = '0; mst.arid = '0; mst.araddr = '0;
    mst.arlen = '0; mst.arsize = '0; mst.arburst = '0;
    mst.rready = '0; slv.arready = 1'b0; slv.rvalid = 1'b0;
    slv.rid = '0; slv.rdata = '0; slv.rresp = '0; slv.rlast = 1'b0;
  endtask

  task automatic step();
    int w;
    int rm;
    bit ahs, rhs, idl;
    logic [N-1:0] el;
    ar_exp_t a;
    r_exp_t r;
    cur_cyc++;
    for (int m = 0; m < N; m++) begin
      if (!pv[m] && $urandom_range(99) < p_req) begin
        pv[m] = 1; pid[m] = IW'($urandom); paddr[m] = AW'($urandom);
        plen[m] = LW'($urandom_range(3));
        psize[m] = SW'($urandom); pburst[m] = BW'($urandom);
      end
      mst.arvalid[m] = pv[m];
      mst.arid[m*IW +: IW] = pid[m];
      mst.araddr[m*AW +: AW] = paddr[m];
      mst.arlen[m*LW +: LW] = plen[m];
      mst.arsize[m*SW +: SW] = psize[m];
      mst.arburst[m*BW +: BW] = pburst[m];
      mst.rready[m] = ($urandom_range(99) < p_rrdy);
    end
    slv.arready = ($urandom_range(99) < p_ardy);
    if (!r_on && bq.size() > 0 && $urandom_range(99) < p_rv) begin
      r_on = 1; r_data = DW'($urandom); r_resp = RW'($urandom);
    end
    slv.rvalid = r_on;
    slv.rdata = r_data;
    slv.rresp = r_resp;
    rm = 0;
    if (bq.size() > 0) begin
      rm = bq[0].m;
      slv.rid = {IDX_W'(rm), bq[0].id};
      slv.rlast = (beat == bq[0].len);
    end else begin
      slv.rid = '0; slv.rlast = 1'b0;
    end
    for (int m = 0; m < N; m++) el[m] = pv[m] && cnt[m] < OST;
    w = lck ? lck_m : pick(el);
    ahs = (w >= 0) && slv.arready;
    idl = (w < 0);
    for (int m = 0; m < N; m++) if (cnt[m] != 0) idl = 0;
    sq.push_back('{cur_cyc, (w >= 0), idl});
    if (w >= 0) begin
      a.cyc = cur_cyc; a.m = w; a.id = pid[w]; a.addr = paddr[w];
      a.len = plen[w]; a.size = psize[w]; a.burst = pburst[w];
      a.ardy = ahs ? N'(1) << w : '0;
      aq.push_back(a);
    end
    rhs = 0;
    if (r_on) begin
      r.cyc = cur_cyc; r.m = rm; r.id = bq[0].id; r.data = r_data;
      r.resp = r_resp; r.last = (beat == bq[0].len);
      r.rrdy = mst.rready[rm];
      rhs = r.rrdy;
      rq.push_back(r);
    end
    @(posedge clk);
    if (rhs) begin
      if (beat == bq[0].len) begin
        cnt[rm]--; void'(bq.pop_front()); beat = 0;
      end else beat++;
      r_on = 0;
    end
    if (ahs) begin
      cnt[w]++; last = w; pv[w] = 0;
      bq.push_back('{w, pid[w], int'(plen[w])});
    end
    lck = (w >= 0) && !ahs;
    lck_m = w;
    #1;
  endtask

  task automatic phase(input int rq_p, input int ar_p, input int rv_p,
                       input int rr_p, input int n);
    p_req = rq_p; p_ardy = ar_p; p_rv = rv_p; p_rrdy = rr_p;
    repeat (n) step();
  endtask

  task automatic leftovers();
    chk("ar_leftover", 64'(aq.size()), 0);
    chk("r_leftover", 64'(rq.size()), 0);
    aq.delete(); rq.delete(); sq.delete();
  endtask

  task automatic monitor_cycle();
    st_exp_t s;
    ar_exp_t a;
    r_exp_t r;
    if (sq.size() == 0) miss("status_queue");
    else begin
      s = sq.pop_front();
      chk("slv_arvalid", 64'(slv.arvalid), 64'(s.arv));
      chk("idle", 64'(idle), 64'(s.idl));
    end
    while (aq.size() > 0 && aq[0].cyc < cur_cyc) begin
      miss("ar_missing"); void'(aq.pop_front());
    end
    if (slv.arvalid) begin
      if (aq.size() > 0 && aq[0].cyc == cur_cyc) begin
        a = aq.pop_front();
        chk("slv_arid", 64'(slv.arid), 64'({IDX_W'(a.m), a.id}));
        chk("slv_araddr", 64'(slv.araddr), 64'(a.addr));
        chk("slv_arlen", 64'(slv.arlen), 64'(a.len));
        chk("slv_arsize", 64'(slv.arsize), 64'(a.size));
        chk("slv_arburst", 64'(slv.arburst), 64'(a.burst));
        chk("mst_arready", 64'(mst.arready), 64'(a.ardy));
      end else begin
        n_chk++;
        $display("FAIL ar_unexpected: got arid %0h expected none",
                 slv.arid);
      end
    end else chk("mst_arready_idle", 64'(mst.arready), 0);
    while (rq.size() > 0 && rq[0].cyc < cur_cyc) begin
      miss("r_missing"); void'(rq.pop_front());
    end
    if (|mst.rvalid) begin
      if (rq.size() > 0 && rq[0].cyc == cur_cyc) begin
        r = rq.pop_front();
        chk("mst_rvalid", 64'(mst.rvalid), 64'(N'(1) << r.m));
        chk("mst_rid", 64'(mst.rid), 64'(r.id));
        chk("mst_rdata", 64'(mst.rdata), 64'(r.data));
        chk("mst_rresp", 64'(mst.rresp), 64'(r.resp));
        chk("mst_rlast", 64'(mst.rlast), 64'(r.last));
        chk("slv_rready", 64'(slv.rready), 64'(r.rrdy));
      end else begin
        n_chk++;
        $display("FAIL r_unexpected: got rvalid %0b expected 0",
                 mst.rvalid);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) monitor_cycle();
    end
  end

  initial begin
    int g;
    bit busy;
    drive_zero();
    r_data = '0; r_resp = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slv_arvalid", 64'(slv.arvalid), 0);
    chk("rst_mst_arready", 64'(mst.arready), 0);
    chk("rst_mst_rvalid", 64'(mst.rvalid), 0);
    chk("rst_slv_rready", 64'(slv.rready), 0);
    chk("rst_idle", 64'(idle), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(idle), 1);

    mon_en = 1;
    phase(100, 100, 100, 100, 24);
    phase(70, 30, 60, 60, 150);
    phase(90, 90, 0, 100, 20);
    phase(50, 70, 80, 40, 150);
    mon_en = 0;
    leftovers();

    phase(100, 100, 0, 100, 0);
    drive_zero();
    for (int m = 0; m < N; m++) pv[m] = 0;
    p_req = 100; p_ardy = 100; p_rv = 0;
    mon_en = 1;
    repeat (4) step();
    mon_en = 0;
    leftovers();
    drive_zero();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_idle", 64'(idle), 1);
    chk("midrst_slv_arvalid", 64'(slv.arvalid), 0);
    chk("midrst_mst_arready", 64'(mst.arready), 0);
    chk("midrst_mst_rvalid", 64'(mst.rvalid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    mon_en = 1;
    phase(80, 80, 80, 80, 150);
    p_req = 0; p_ardy = 100; p_rv = 100; p_rrdy = 100;
    g = 0;
    busy = 1;
    while (busy && g < 500) begin
      busy = (bq.size() > 0) || r_on;
      for (int m = 0; m < N; m++) if (pv[m]) busy = 1;
      if (busy) step();
      g++;
    end
    mon_en = 0;
    chk("drain_done", 64'(busy), 0);
    leftovers();
    drive_zero();
    #1;
    chk("final_idle", 64'(idle), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
